map_compositor: RTL and testbench
=================================

# map_compositor

Parametrised tile-map compositor placed between the map BRAM and the tile renderer. On each `start` it scans the MAP_W × MAP_H grid of the selected map and fetches every cell's tile id from BRAM. It overlays up to N_ENT entity sprites using fixed priority, applies a frame-consistent animation offset, and streams the composed tiles to the renderer over a valid/ready handshake.

## Interface
- `MAP_W`, 16: grid width in cells (≥2).
- `MAP_H`, 16: grid height in cells (≥2).
- `N_ENT`, 4: number of entity overlay channels (1..8).
- `ADDR_W`, 19: BRAM address width.
- `TILE_W`, 16: tile id width.
- `BRAM_LAT`, 1: BRAM read latency in cycles (1..3).
- `ANIM_LOG2`, 1: log2 of animation frame count.
- `ANIM_BASE`, 16'h0100: first animated tile id; ids ≥ ANIM_BASE are animated.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a scan; ignored while `busy`.
- `map_id` in ADDR_W: map select, latched on accepted `start`.
- `ent_en` in N_ENT: per-entity enable, latched on `start`.
- `ent_x`, `ent_y` in N_ENT×4: packed entity cell coordinates, latched on `start`.
- `ent_tile` in N_ENT×TILE_W: packed entity tile ids, latched on `start`.
- `anim_tick` in 1: pulse that advances the animation frame.
- `bram_addr` out ADDR_W: map BRAM read address.
- `bram_data` in TILE_W: BRAM read data, valid BRAM_LAT cycles after the address.
- `tile_valid` out 1: composed tile available.
- `tile_ready` in 1: renderer accepts the tile.
- `tile_id` out TILE_W: composed tile id.
- `grid_x`, `grid_y` out 4: cell coordinates of `tile_id`.
- `tile_last` out 1: asserted with the final cell of a scan.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse after the last cell is accepted.

## Operation
- **Address:** `(map_id*MAP_W*MAP_H + y*MAP_W + x)`, truncated to ADDR_W.
- **Scan order:** row-major. x runs 0..MAP_W-1 and wraps to 0 with y+1. The scan ends after cell (MAP_W-1, MAP_H-1).
- **FSM states:**
  - IDLE: on `start`, latch inputs and the current frame; x=y=0; go to FETCH.
  - FETCH: drive `bram_addr`; go to WAIT.
  - WAIT: count BRAM_LAT cycles; go to COMPOSE.
  - COMPOSE: compute the composed id into the output register; go to EMIT.
  - EMIT: hold `tile_valid` until `tile_ready`. On the handshake, advance to FETCH for the next cell, or to DONE after the last cell.
  - DONE: pulse `done`; go to IDLE.
- **Overlay:** the lowest-index enabled entity whose (x,y) matches the cell replaces the BRAM tile. If no entity matches, the BRAM tile is used.
- **Animation:** if the composed id ≥ ANIM_BASE, its low ANIM_LOG2 bits are replaced by the latched frame. Other ids pass through unchanged.
- **Frame counter:** ANIM_LOG2 bits wide. Increments on `anim_tick` and wraps modulo 2^ANIM_LOG2. It runs in every state, but a scan uses only the frame latched at `start`.
- **`start` and `anim_tick` in the same cycle:** the pre-increment frame is latched.
- **Output stability:** `tile_id`, `grid_x`, `grid_y` and `tile_last` stay stable while `tile_valid` is high and `tile_ready` is low.
- **`rst` mid-scan:** the scan is abandoned and `done` is not pulsed.

## Timing
- Reset values:
  - `tile_valid`, `tile_last`, `busy`, `done`, `bram_addr`, `tile_id`, `grid_x`, `grid_y` = 0.
  - Frame counter = 0; state = IDLE.
- `busy` goes high the cycle after an accepted `start`. It goes low in the cycle that `done` pulses.
- First `tile_valid` appears BRAM_LAT+3 cycles after `start`.
- With `tile_ready` held high, one tile is emitted every BRAM_LAT+3 cycles.
- A full scan takes MAP_W·MAP_H·(BRAM_LAT+3)+2 cycles.
- `tile_valid` drops the cycle after the handshake.
- A `start` while `busy` is high is ignored with no side effects.

## Configuration
- Macro `MAP_COMPOSITOR_ANIM_EN`.
- **Defined:** frame counter and animation substitution operate as described above.
- **Undefined:** `anim_tick` is ignored and no frame counter is built. The composed id is output unmodified. All timing is unchanged.

## Test plan
- **Plain scan:** MAP_W=MAP_H=4, BRAM holds `addr`, map_id=2, no entities, `tile_ready`=1. Expect 16 tiles with ids 32..47 in row-major order, `tile_last` only on (3,3), then one `done` pulse.
- **Overlay priority:** ent0 and ent1 both at (1,2) with tiles 0x0010 and 0x0020, ent2 disabled at (0,0). Expect cell (1,2)=0x0010 and cell (0,0)=BRAM value.
- **Animation:** ANIM_LOG2=1, BRAM tile 0x0102, with `anim_tick` pulses before `start` as follows:
  - one pulse: expect 0x0103;
  - two pulses: expect 0x0102;
  - tile 0x00FF: expect it unchanged.
  - Also pulse `anim_tick` mid-scan and check the frame does not change within that scan.
- **Backpressure:** randomly deassert `tile_ready`. Outputs must stay stable while stalled, and no cell may be dropped or duplicated.
- **Reset and ignored start:** assert `rst` at cell 5 and expect all outputs 0 and no `done`; then `start` again and expect a full scan from (0,0). A `start` pulse mid-scan must be ignored.

Source files
------------

// File: rtl/map_compositor.sv
// Tile-map compositor: scans a MAP_W x MAP_H map from BRAM, overlays entity sprites and
// streams composed tiles over valid/ready. Define MAP_COMPOSITOR_ANIM_EN for frame animation.
module map_compositor #(
  parameter int unsigned       MAP_W     = 16,
  parameter int unsigned       MAP_H     = 16,
  parameter int unsigned       N_ENT     = 4,
  parameter int unsigned       ADDR_W    = 19,
  parameter int unsigned       TILE_W    = 16,
  parameter int unsigned       BRAM_LAT  = 1,
  parameter int unsigned       ANIM_LOG2 = 1,
  parameter logic [TILE_W-1:0] ANIM_BASE = 16'h0100
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       map_id_i,
  input  logic [N_ENT-1:0]        ent_en_i,
  input  logic [N_ENT*4-1:0]      ent_x_i,
  input  logic [N_ENT*4-1:0]      ent_y_i,
  input  logic [N_ENT*TILE_W-1:0] ent_tile_i,
  input  logic                    anim_tick_i,
  output logic [ADDR_W-1:0]       bram_addr_o,
  input  logic [TILE_W-1:0]       bram_data_i,
  output logic                    tile_valid_o,
  input  logic                    tile_ready_i,
  output logic [TILE_W-1:0]       tile_id_o,
  output logic [3:0]              grid_x_o,
  output logic [3:0]              grid_y_o,
  output logic                    tile_last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPOSE = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] CELLS_A   = ADDR_W'(MAP_W * MAP_H);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(32'd1);
  localparam logic [3:0]        X_LAST    = 4'(MAP_W - 32'd1);
  localparam logic [3:0]        Y_LAST    = 4'(MAP_H - 32'd1);
  localparam logic [1:0]        WAIT_INIT = 2'(BRAM_LAT - 32'd1);

  state_t                  state_q;
  logic [3:0]              x_q;
  logic [3:0]              y_q;
  logic [ADDR_W-1:0]       cell_q;
  logic [ADDR_W-1:0]       base_q;
  logic [1:0]              wait_q;
  logic [TILE_W-1:0]       data_q;
  logic [N_ENT-1:0]        ent_en_q;
  logic [N_ENT*4-1:0]      ent_x_q;
  logic [N_ENT*4-1:0]      ent_y_q;
  logic [N_ENT*TILE_W-1:0] ent_tile_q;

  logic [ADDR_W-1:0]       bram_addr_q;
  logic                    tile_valid_q;
  logic [TILE_W-1:0]       tile_id_q;
  logic [3:0]              grid_x_q;
  logic [3:0]              grid_y_q;
  logic                    tile_last_q;
  logic                    busy_q;
  logic                    done_q;

  logic [TILE_W-1:0]       overlay_d;
  logic [TILE_W-1:0]       composed_d;
  logic                    last_cell_s;

  assign last_cell_s = (x_q == X_LAST) && (y_q == Y_LAST);

  // Overlay: walk from the highest index down so the lowest enabled match wins.
  always_comb begin
    overlay_d = data_q;
    for (int i = N_ENT - 1; i >= 0; i--) begin
      overlay_d = (ent_en_q[i] && (ent_x_q[i*4 +: 4] == x_q) && (ent_y_q[i*4 +: 4] == y_q))
                  ? ent_tile_q[i*TILE_W +: TILE_W] : overlay_d;
    end
  end

`ifdef MAP_COMPOSITOR_ANIM_EN
  localparam logic [ANIM_LOG2-1:0] FRAME_ONE = ANIM_LOG2'(32'd1);

  logic [ANIM_LOG2-1:0] frame_q;
  logic [ANIM_LOG2-1:0] frame_lat_q;

  // Free-running frame counter; a scan only sees the value captured when it is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q     <= '0;
      frame_lat_q <= '0;
    end else begin
      if (anim_tick_i) begin
        frame_q <= frame_q + FRAME_ONE;
      end
      if ((state_q == S_IDLE) && start_i) begin
        frame_lat_q <= frame_q;
      end
    end
  end

  // Animated ids carry the latched frame in their low bits.
  always_comb begin
    composed_d = overlay_d;
    if (overlay_d >= ANIM_BASE) begin
      composed_d = {overlay_d[TILE_W-1:ANIM_LOG2], frame_lat_q};
    end else begin
      composed_d = overlay_d;
    end
  end
`else
  logic unused_anim_s;
  assign unused_anim_s = anim_tick_i ^ (ANIM_BASE == '0) ^ (ANIM_LOG2 == 32'd0);

  // Without animation the overlay result goes out untouched.
  always_comb begin
    composed_d = overlay_d;
  end
`endif

  // Scan sequencer with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      x_q          <= 4'd0;
      y_q          <= 4'd0;
      cell_q       <= '0;
      base_q       <= '0;
      wait_q       <= 2'd0;
      data_q       <= '0;
      ent_en_q     <= '0;
      ent_x_q      <= '0;
      ent_y_q      <= '0;
      ent_tile_q   <= '0;
      bram_addr_q  <= '0;
      tile_valid_q <= 1'b0;
      tile_id_q    <= '0;
      grid_x_q     <= 4'd0;
      grid_y_q     <= 4'd0;
      tile_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            ent_en_q    <= ent_en_i;
            ent_x_q     <= ent_x_i;
            ent_y_q     <= ent_y_i;
            ent_tile_q  <= ent_tile_i;
            base_q      <= map_id_i * CELLS_A;
            bram_addr_q <= map_id_i * CELLS_A;
            x_q         <= 4'd0;
            y_q         <= 4'd0;
            cell_q      <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: begin
          wait_q  <= WAIT_INIT;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // The last wait cycle is the one in which the read data is valid.
          if (wait_q == 2'd0) begin
            data_q  <= bram_data_i;
            state_q <= S_COMPOSE;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        S_COMPOSE: begin
          tile_id_q    <= composed_d;
          grid_x_q     <= x_q;
          grid_y_q     <= y_q;
          tile_last_q  <= last_cell_s;
          tile_valid_q <= 1'b1;
          state_q      <= S_EMIT;
        end
        S_EMIT: begin
          if (tile_ready_i) begin
            tile_valid_q <= 1'b0;
            if (last_cell_s) begin
              tile_last_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              if (x_q == X_LAST) begin
                x_q <= 4'd0;
                y_q <= y_q + 4'd1;
              end else begin
                x_q <= x_q + 4'd1;
              end
              cell_q      <= cell_q + ONE_A;
              bram_addr_q <= base_q + cell_q + ONE_A;
              state_q     <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          tile_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          done_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bram_addr_o  = bram_addr_q;
  assign tile_valid_o = tile_valid_q;
  assign tile_id_o    = tile_id_q;
  assign grid_x_o     = grid_x_q;
  assign grid_y_o     = grid_y_q;
  assign tile_last_o  = tile_last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_map_compositor.sv
// Directed testbench for map_compositor on a 4x4 map with a two-cycle BRAM that returns its address.
module tb_map_compositor;

  localparam int MW  = 4;
  localparam int MH  = 4;
  localparam int NE  = 4;
  localparam int AW  = 19;
  localparam int TW  = 16;
  localparam int LAT = 2;
`ifdef MAP_COMPOSITOR_ANIM_EN
  localparam bit ANIM_ON = 1'b1;
`else
  localparam bit ANIM_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] map_id;
  logic [NE-1:0] ent_en;
  logic [NE*4-1:0] ent_x;
  logic [NE*4-1:0] ent_y;
  logic [NE*TW-1:0] ent_tile;
  logic          anim_tick;
  logic [AW-1:0] bram_addr;
  logic [TW-1:0] bram_data;
  logic          tile_valid;
  logic          tile_ready;
  logic [TW-1:0] tile_id;
  logic [3:0]    grid_x;
  logic [3:0]    grid_y;
  logic          tile_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  map_compositor #(
    .MAP_W(MW), .MAP_H(MH), .N_ENT(NE), .ADDR_W(AW), .TILE_W(TW),
    .BRAM_LAT(LAT), .ANIM_LOG2(1), .ANIM_BASE(16'h0100)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .map_id_i(map_id),
    .ent_en_i(ent_en), .ent_x_i(ent_x), .ent_y_i(ent_y), .ent_tile_i(ent_tile),
    .anim_tick_i(anim_tick), .bram_addr_o(bram_addr), .bram_data_i(bram_data),
    .tile_valid_o(tile_valid), .tile_ready_i(tile_ready), .tile_id_o(tile_id),
    .grid_x_o(grid_x), .grid_y_o(grid_y), .tile_last_o(tile_last),
    .busy_o(busy), .done_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage BRAM model whose content equals the low address bits.
  logic [TW-1:0] pipe0, pipe1;
  always @(posedge clk) begin
    pipe0 <= bram_addr[TW-1:0];
    pipe1 <= pipe0;
  end
  assign bram_data = pipe1;

  // Results of the most recent scan.
  logic [24:0] c_rec[64];
  int c_n, c_first, c_done_k, c_done_cnt, c_stall_bad;
  bit c_timeout, c_busy1, c_busy_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] m, input bit with_tick);
    map_id    = m;
    start     = 1'b1;
    anim_tick = with_tick;
    tick();
    start     = 1'b0;
    anim_tick = 1'b0;
  endtask

  task automatic pulse_anim();
    anim_tick = 1'b1;
    tick();
    anim_tick = 1'b0;
  endtask

  // Drives ready (and optional mid-scan tick / stray start) and records every handshake.
  task automatic collect(input bit rnd, input int stop_n, input int tick_at, input int ign_at);
    logic [AW-1:0] cur_map;
    logic [24:0]   prev_out;
    bit            prev_stall;
    bit            finished;
    cur_map = map_id;
    for (int i = 0; i < 64; i++) c_rec[i] = 'x;
    c_n = 0; c_first = -1; c_done_k = -1; c_done_cnt = 0; c_stall_bad = 0;
    c_timeout = 1'b0; c_busy1 = 1'b0; c_busy_done = 1'b1;
    prev_stall = 1'b0; prev_out = '0; finished = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      tile_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      anim_tick  = (k == tick_at);
      start      = (k == ign_at);
      map_id     = (k == ign_at) ? 19'd5 : cur_map;
      if (k == 1) c_busy1 = busy;
      if (prev_stall && (!tile_valid || ({tile_id, grid_x, grid_y, tile_last} != prev_out)))
        c_stall_bad++;
      prev_stall = tile_valid && !tile_ready;
      prev_out   = {tile_id, grid_x, grid_y, tile_last};
      if (tile_valid && c_first < 0) c_first = k;
      if (tile_valid && tile_ready) begin
        c_rec[c_n] = {tile_id, grid_x, grid_y, tile_last};
        c_n++;
      end
      if (done) begin
        c_done_cnt++;
        c_done_k    = k;
        c_busy_done = busy;
      end
      if (done || (stop_n > 0 && c_n == stop_n)) begin
        finished = 1'b1;
        break;
      end
      tick();
    end
    c_timeout  = !finished;
    start      = 1'b0;
    anim_tick  = 1'b0;
    map_id     = cur_map;
    tile_ready = 1'b1;
  endtask

  function automatic logic [24:0] exp_rec(input logic [TW-1:0] id, input int i);
    return {id, 4'(i % MW), 4'(i / MW), (i == MW * MH - 1)};
  endfunction

  function automatic logic [TW-1:0] anim(input logic [TW-1:0] v, input logic f);
    return (ANIM_ON && v >= 16'h0100) ? {v[TW-1:1], f} : v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({tile_valid, tile_last, busy, done, bram_addr, tile_id, grid_x, grid_y} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%b a=%h id=%h x=%h y=%h, all zero required",
               tile_valid, tile_last, busy, done, bram_addr, tile_id, grid_x, grid_y);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_plain_scan();
    logic [24:0] e;
    ent_en = '0;
    do_start(19'd2, 1'b0);
    checks++;
    if (busy !== 1'b1 || bram_addr !== 19'd32) begin
      errors++;
      $display("FAIL plain_first_fetch: busy=%b addr=%0d, required busy=1 addr=32", busy, bram_addr);
    end
    collect(1'b0, 0, -1, -1);
    checks++;
    if (c_timeout || c_n != 16) begin
      errors++;
      $display("FAIL plain_count: got %0d tiles timeout=%b, required 16", c_n, c_timeout);
    end
    checks++;
    if (c_first != LAT + 3) begin
      errors++;
      $display("FAIL plain_first_valid: got cycle %0d, required %0d", c_first, LAT + 3);
    end
    checks++;
    if (c_done_k != 16 * (LAT + 3) + 1 || c_done_cnt != 1 || c_busy_done !== 1'b0) begin
      errors++;
      $display("FAIL plain_done: cycle %0d cnt %0d busy %b, required cycle %0d cnt 1 busy 0",
               c_done_k, c_done_cnt, c_busy_done, 16 * (LAT + 3) + 1);
    end
    for (int i = 0; i < 16; i++) begin
      e = exp_rec(16'(32 + i), i);
      checks++;
      if (c_rec[i] !== e) begin
        errors++;
        $display("FAIL plain_tile[%0d]: got %h, required %h", i, c_rec[i], e);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL plain_after_done: done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_overlay();
    logic [24:0] e;
    ent_en   = 4'b0011;
    ent_x    = {4'd0, 4'd0, 4'd1, 4'd1};
    ent_y    = {4'd0, 4'd0, 4'd2, 4'd2};
    ent_tile = {16'h0000, 16'h0030, 16'h0020, 16'h0010};
    do_start(19'd0, 1'b0);
    collect(1'b0, 0, -1, -1);
    checks++;
    if (c_timeout || c_n != 16) begin
      errors++;
      $display("FAIL overlay_count: got %0d tiles, required 16", c_n);
    end
    for (int i = 0; i < 16; i++) begin
      e = exp_rec((i == 9) ? 16'h0010 : 16'(i), i);
      checks++;
      if (c_rec[i] !== e) begin
        errors++;
        $display("FAIL overlay_prio[%0d]: got %h, required %h", i, c_rec[i], e);
      end
    end
    tick();
    ent_en   = 4'b0110;
    ent_x    = {4'd0, 4'd3, 4'd1, 4'd1};
    ent_y    = {4'd0, 4'd3, 4'd2, 4'd2};
    ent_tile = {16'h0000, 16'h0040, 16'h0020, 16'h0010};
    do_start(19'd0, 1'b0);
    collect(1'b0, 0, -1, -1);
    for (int i = 0; i < 16; i++) begin
      e = exp_rec((i == 9) ? 16'h0020 : (i == 15) ? 16'h0040 : 16'(i), i);
      checks++;
      if (c_rec[i] !== e) begin
        errors++;
        $display("FAIL overlay_en[%0d]: got %h, required %h", i, c_rec[i], e);
      end
    end
    ent_en = '0;
    tick();
  endtask

  task automatic test_animation();
    logic [24:0] e;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pulse_anim();
    do_start(19'd16, 1'b0);
    collect(1'b0, 0, -1, -1);
    for (int i = 0; i < 16; i++) begin
      e = exp_rec(anim(16'(16'h0100 + i), 1'b1), i);
      checks++;
      if (c_rec[i] !== e) begin
        errors++;
        $display("FAIL anim_one_tick[%0d]: got %h, required %h", i, c_rec[i], e);
      end
    end
    tick();
    pulse_anim();
    do_start(19'd16, 1'b0);
    collect(1'b0, 0, 20, -1);
    for (int i = 0; i < 16; i++) begin
      e = exp_rec(anim(16'(16'h0100 + i), 1'b0), i);
      checks++;
      if (c_rec[i] !== e) begin
        errors++;
        $display("FAIL anim_two_ticks_midscan[%0d]: got %h, required %h", i, c_rec[i], e);
      end
    end
    tick();
    do_start(19'd15, 1'b0);
    collect(1'b0, 0, -1, -1);
    for (int i = 0; i < 16; i++) begin
      e = exp_rec(16'(16'h00F0 + i), i);
      checks++;
      if (c_rec[i] !== e) begin
        errors++;
        $display("FAIL anim_static[%0d]: got %h, required %h", i, c_rec[i], e);
      end
    end
    tick();
    do_start(19'd16, 1'b1);
    collect(1'b0, 0, -1, -1);
    e = exp_rec(anim(16'h0102, 1'b1), 2);
    checks++;
    if (c_rec[2] !== e) begin
      errors++;
      $display("FAIL anim_start_with_tick: got %h, required %h", c_rec[2], e);
    end
    tick();
    do_start(19'd16, 1'b0);
    collect(1'b0, 0, -1, -1);
    e = exp_rec(anim(16'h0103, 1'b0), 3);
    checks++;
    if (c_rec[3] !== e) begin
      errors++;
      $display("FAIL anim_after_same_cycle: got %h, required %h", c_rec[3], e);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [24:0] e;
    ent_en   = 4'b1000;
    ent_x    = {4'd2, 4'd0, 4'd0, 4'd0};
    ent_y    = {4'd1, 4'd0, 4'd0, 4'd0};
    ent_tile = {16'h0077, 16'h0000, 16'h0000, 16'h0000};
    do_start(19'd3, 1'b0);
    collect(1'b1, 0, -1, -1);
    checks++;
    if (c_timeout || c_n != 16 || c_done_cnt != 1) begin
      errors++;
      $display("FAIL bp_count: got %0d tiles %0d done timeout=%b, required 16 tiles 1 done",
               c_n, c_done_cnt, c_timeout);
    end
    checks++;
    if (c_stall_bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable stall cycles, required 0", c_stall_bad);
    end
    for (int i = 0; i < 16; i++) begin
      e = exp_rec((i == 6) ? 16'h0077 : 16'(48 + i), i);
      checks++;
      if (c_rec[i] !== e) begin
        errors++;
        $display("FAIL bp_tile[%0d]: got %h, required %h", i, c_rec[i], e);
      end
    end
    ent_en = '0;
    tick();
  endtask

  task automatic test_reset_midscan();
    logic [24:0] e;
    int          bad;
    do_start(19'd2, 1'b0);
    collect(1'b0, 5, -1, 3);
    for (int i = 0; i < 5; i++) begin
      e = exp_rec(16'(32 + i), i);
      checks++;
      if (c_rec[i] !== e) begin
        errors++;
        $display("FAIL ignored_start[%0d]: got %h, required %h", i, c_rec[i], e);
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({tile_valid, tile_last, busy, done, bram_addr, tile_id, grid_x, grid_y} !== '0) begin
      errors++;
      $display("FAIL midscan_reset: got v=%b b=%b d=%b a=%h id=%h, all zero required",
               tile_valid, busy, done, bram_addr, tile_id);
    end
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (done !== 1'b0 || tile_valid !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midscan_no_done: got %0d cycles with done/valid, required 0", bad);
    end
    do_start(19'd2, 1'b0);
    collect(1'b0, 0, -1, -1);
    checks++;
    if (c_timeout || c_n != 16 || c_done_cnt != 1) begin
      errors++;
      $display("FAIL restart_count: got %0d tiles %0d done, required 16 and 1", c_n, c_done_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      e = exp_rec(16'(32 + i), i);
      checks++;
      if (c_rec[i] !== e) begin
        errors++;
        $display("FAIL restart_tile[%0d]: got %h, required %h", i, c_rec[i], e);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; map_id = '0; ent_en = '0; ent_x = '0; ent_y = '0;
    ent_tile = '0; anim_tick = 1'b0; tile_ready = 1'b1;
    test_reset();
    test_plain_scan();
    test_overlay();
    test_animation();
    test_backpressure();
    test_reset_midscan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
